div_unit: RTL and testbench
===========================

# div_unit

Sequential unsigned restoring divider; the inverse-direction companion to the team's Booth multiplier unit. It shares the same byte-wide `inbus`/`outbus` convention and the same `start`/`enable` control style. Operands arrive serially on `inbus` (divisor, then dividend). The block iterates one quotient bit per three-cycle step and returns the remainder, then the quotient, on `outbus`. It sits beside the multiplier under the ALU top-level, sharing its input/output buses.

## Interface
- `WIDTH`, default 8: operand/result width in bits; the iteration counter is `$clog2(WIDTH)` bits.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `enable`, input, 1: unit enable; low forces FSM to IDLE on the next edge.
- `start`, input, 1: begin operation; sampled only in IDLE with `enable`=1.
- `inbus`, input, WIDTH: operand bus; divisor in LOAD_M, dividend in LOAD_Q.
- `outbus`, output, WIDTH: result bus; 0 when `out_valid`=0.
- `out_valid`, output, 1: `outbus` holds a result this cycle.
- `out_sel`, output, 1: 0 = remainder, 1 = quotient (meaningful while `out_valid`=1).
- `busy`, output, 1: FSM not in IDLE.
- `div_by_zero`, output, 1: divisor was 0 for the current/last result (see Configuration).

## Operation
- Registers:
  - A: WIDTH+1 bits (partial remainder).
  - Q: WIDTH bits (dividend → quotient).
  - M: WIDTH bits (divisor).
  - cnt: counter.
- FSM states, 4-bit codes from the package:
  - IDLE: `start`&`enable` → LOAD_M; otherwise stay.
  - LOAD_M: M←`inbus`, cnt←0, `div_by_zero`←0 → LOAD_Q.
  - LOAD_Q: Q←`inbus`, A←0 → SHIFT.
  - SHIFT: {A,Q}←{A,Q}<<1 → TEST.
  - TEST: trial = A − {0,M} (WIDTH+1 bits).
    - trial MSB = 0: A←trial, Q[0]←1.
    - trial MSB = 1: A unchanged, Q[0]←0.
    - → COUNT.
  - COUNT: cnt←cnt+1; cnt==WIDTH−1 → OUT_R, else → SHIFT.
  - OUT_R: `outbus`=A[WIDTH−1:0], `out_valid`=1, `out_sel`=0 → OUT_Q.
  - OUT_Q: `outbus`=Q, `out_valid`=1, `out_sel`=1 → IDLE.
- `enable`=0 in any state: next state IDLE.
  - Datapath registers hold their values; no output is produced for the aborted operation.
  - `div_by_zero` keeps its value.
- `start` in any non-IDLE state is ignored.
- Outputs are decoded from state (Moore). `outbus`, `out_valid`, `out_sel` and `busy` are combinational from registered state/data.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State IDLE; A, Q, M, cnt = 0.
  - `outbus`=0, `out_valid`=0, `out_sel`=0, `busy`=0, `div_by_zero`=0.
- Cycle numbering: `start` sampled at edge 0.
  - Divisor must be on `inbus` in cycle 1; dividend in cycle 2.
  - Iterations occupy cycles 3–(3+3·WIDTH−1): 24 cycles for WIDTH=8.
  - Remainder appears in cycle 3·WIDTH+3 (27); quotient in cycle 28; IDLE in cycle 29.
- Back-to-back: `start` may be asserted in the first IDLE cycle after OUT_Q. Minimum period is 3·WIDTH+5 cycles.
- `rst_n` asserted mid-operation: immediate return to reset values; no partial output.

## Configuration
- `DIV_ZERO_CHECK_EN` defined:
  - In LOAD_Q, if M==0: A←{0,`inbus`}, Q←all-ones, `div_by_zero`←1, next state OUT_R.
  - Results appear 3 cycles after `start` instead of 27.
  - `div_by_zero` holds until the next LOAD_M.
- `DIV_ZERO_CHECK_EN` undefined:
  - `div_by_zero` is tied 0.
  - Division by zero runs the full iteration and naturally yields Q=all-ones, R=dividend, with normal latency.

## Structure
- `div_pkg` holds:
  - The state enum/localparams: IDLE=0, LOAD_M=1, LOAD_Q=2, SHIFT=3, TEST=4, COUNT=5, OUT_R=6, OUT_Q=7.
  - The `out_sel` codes.
- One sub-module, `div_ctrl`, is natural:
  - Contents: FSM plus counter-done decode.
  - Inputs: `enable`, `start`, `cnt_done`, `m_zero`, `trial_msb`.
  - Outputs: one-hot load/shift/update/increment/output strobes.
- The `div_unit` top holds the A/Q/M/cnt registers and the subtractor.

## Test plan
- Divisor 7, dividend 100 → cycle 27: `outbus`=2, `out_sel`=0; cycle 28: `outbus`=14, `out_sel`=1; `busy` low in cycle 29.
- Divisor 1, dividend 255 → R=0, Q=255. Then divisor 9, dividend 5 → R=5, Q=0. Issue the second `start` in the first IDLE cycle after the first OUT_Q.
- Divisor 0, dividend 0x5A:
  - With the macro: cycle 3 R=0x5A, cycle 4 Q=0xFF, `div_by_zero`=1.
  - Without the macro: same values at cycles 27/28, `div_by_zero`=0.
- Drop `enable` in cycle 10 → IDLE at edge 11, `busy`=0, no `out_valid` pulse. A fresh `start` then gives the correct result for 200/13 (R=5, Q=15).
- Pulse `start` during cycles 5 and 20 of an operation → ignored; the result is unchanged and appears exactly at cycles 27/28.
- Assert `rst_n`=0 asynchronously mid-TEST → all outputs 0 immediately; resume from IDLE after release.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state codes and out_sel codes for the div_unit divider.
// Optional feature macro used by div_unit/div_ctrl: DIV_ZERO_CHECK_EN.
package div_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LOAD_M = 4'd1,
      LOAD_Q = 4'd2,
      SHIFT  = 4'd3,
      TEST   = 4'd4,
      COUNT  = 4'd5,
      OUT_R  = 4'd6,
      OUT_Q  = 4'd7
   } div_state_e;

   localparam logic OSEL_REM = 1'b0;
   localparam logic OSEL_QUO = 1'b1;

   function automatic logic is_out_state(div_state_e s);
      return (s == OUT_R) || (s == OUT_Q);
   endfunction

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: sequencing FSM of the restoring divider, one-hot strobes.
// Macro DIV_ZERO_CHECK_EN adds the zero-divisor shortcut out of LOAD_Q.
module div_ctrl
   import div_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic enable_i,
   input  logic start_i,
   input  logic cnt_done_i,
   input  logic m_zero_i,
   input  logic trial_msb_i,
   output logic load_m_o,
   output logic load_q_o,
   output logic dz_o,
   output logic shift_o,
   output logic test_o,
   output logic upd_o,
   output logic inc_o,
   output logic out_r_o,
   output logic out_q_o,
   output logic busy_o
);

   div_state_e state_q;
   logic       dz_take;

`ifdef DIV_ZERO_CHECK_EN
   assign dz_take = m_zero_i;
`else
   logic unused_m_zero;
   assign unused_m_zero = m_zero_i;
   assign dz_take = 1'b0;
`endif

   // State register; a low enable aborts to IDLE from anywhere
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else if (!enable_i) begin
         state_q <= IDLE;
      end else begin
         unique case (state_q)
            IDLE:    state_q <= start_i ? LOAD_M : IDLE;
            LOAD_M:  state_q <= LOAD_Q;
            LOAD_Q:  state_q <= dz_take ? OUT_R : SHIFT;
            SHIFT:   state_q <= TEST;
            TEST:    state_q <= COUNT;
            COUNT:   state_q <= cnt_done_i ? OUT_R : SHIFT;
            OUT_R:   state_q <= OUT_Q;
            OUT_Q:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Datapath strobes only fire when the unit is enabled, so an
   // aborting cycle leaves A/Q/M/cnt untouched.
   assign load_m_o = enable_i && (state_q == LOAD_M);
   assign load_q_o = enable_i && (state_q == LOAD_Q) && !dz_take;
   assign dz_o     = enable_i && (state_q == LOAD_Q) && dz_take;
   assign shift_o  = enable_i && (state_q == SHIFT);
   assign test_o   = enable_i && (state_q == TEST);
   assign upd_o    = enable_i && (state_q == TEST) && !trial_msb_i;
   assign inc_o    = enable_i && (state_q == COUNT);

   // Output strobes are pure Moore decodes of the state
   assign out_r_o  = is_out_state(state_q) && (state_q == OUT_R);
   assign out_q_o  = (state_q == OUT_Q);
   assign busy_o   = (state_q != IDLE);

endmodule

// File: rtl/div_unit.sv
// div_unit: sequential unsigned restoring divider, byte-bus operand I/O.
// Macro DIV_ZERO_CHECK_EN enables the early divide-by-zero result path.
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             start,
   input  logic [WIDTH-1:0] inbus,
   output logic [WIDTH-1:0] outbus,
   output logic             out_valid,
   output logic             out_sel,
   output logic             busy,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH:0]   a_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] m_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   trial;
   logic             cnt_done;
   logic             m_zero;
   logic             load_m;
   logic             load_q;
   logic             dz;
   logic             shift;
   logic             test;
   logic             upd;
   logic             inc;
   logic             out_r;
   logic             out_q;

   assign trial    = a_q - {1'b0, m_q};
   assign cnt_done = (cnt_q == CW'(WIDTH - 1));
   assign m_zero   = (m_q == '0);

   div_ctrl u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable_i    (enable),
      .start_i     (start),
      .cnt_done_i  (cnt_done),
      .m_zero_i    (m_zero),
      .trial_msb_i (trial[WIDTH]),
      .load_m_o    (load_m),
      .load_q_o    (load_q),
      .dz_o        (dz),
      .shift_o     (shift),
      .test_o      (test),
      .upd_o       (upd),
      .inc_o       (inc),
      .out_r_o     (out_r),
      .out_q_o     (out_q),
      .busy_o      (busy)
   );

   // A/Q/M/cnt datapath, each update gated by its one-hot strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         q_q   <= '0;
         m_q   <= '0;
         cnt_q <= '0;
      end else begin
         if (load_m) begin
            m_q   <= inbus;
            cnt_q <= '0;
         end
         if (load_q) begin
            q_q <= inbus;
            a_q <= '0;
         end
         if (dz) begin
            a_q <= {1'b0, inbus};
            q_q <= '1;
         end
         if (shift) begin
            {a_q, q_q} <= {a_q[WIDTH-1:0], q_q, 1'b0};
         end
         if (test) begin
            q_q[0] <= upd;
            if (upd) begin
               a_q <= trial;
            end
         end
         if (inc) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

`ifdef DIV_ZERO_CHECK_EN
   logic dz_q;

   // Sticky zero-divisor flag, cleared when a new divisor is loaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dz_q <= 1'b0;
      end else if (load_m) begin
         dz_q <= 1'b0;
      end else if (dz) begin
         dz_q <= 1'b1;
      end
   end

   assign div_by_zero = dz_q;
`else
   assign div_by_zero = 1'b0;
`endif

   assign out_valid = out_r || out_q;
   assign out_sel   = out_q ? OSEL_QUO : OSEL_REM;
   assign outbus    = out_r ? a_q[WIDTH-1:0] :
                      out_q ? q_q : '0;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit (WIDTH=8).
// Expectations follow DIV_ZERO_CHECK_EN when it is defined.
module tb_div_unit;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       start;
   logic [7:0] inbus;
   logic [7:0] outbus;
   logic       out_valid;
   logic       out_sel;
   logic       busy;
   logic       div_by_zero;

   int n_chk;
   int n_pass;

`ifdef DIV_ZERO_CHECK_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   div_unit #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .start       (start),
      .inbus       (inbus),
      .outbus      (outbus),
      .out_valid   (out_valid),
      .out_sel     (out_sel),
      .busy        (busy),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one division; caller is in an IDLE cycle. Leaves the bench
   // in the first IDLE cycle after OUT_Q so another start can follow.
   task automatic run_op(input string tag, input logic [7:0] m,
                         input logic [7:0] d, input logic [7:0] r,
                         input logic [7:0] q, input bit pulse);
      int  lat;
      bit  dz_exp;
      bit  early;
      dz_exp = DZ_EN && (m == 8'd0);
      lat    = dz_exp ? 3 : 27;
      early  = 1'b0;
      start  = 1'b1;
      inbus  = 8'h00;
      tick();
      start  = 1'b0;
      inbus  = m;
      early |= out_valid;
      tick();
      inbus  = d;
      early |= out_valid;
      tick();
      inbus  = 8'h00;
      check({tag, ".busy3"}, busy, 1);
      for (int c = 3; c < lat; c++) begin
         early |= out_valid;
         start = pulse && (c == 5 || c == 20);
         tick();
      end
      start = 1'b0;
      check({tag, ".rem"}, outbus, r);
      check({tag, ".rvld"}, out_valid, 1);
      check({tag, ".rsel"}, out_sel, 0);
      check({tag, ".dz"}, div_by_zero, dz_exp);
      tick();
      check({tag, ".quo"}, outbus, q);
      check({tag, ".qsel"}, out_sel, 1);
      check({tag, ".qvld"}, out_valid, 1);
      tick();
      check({tag, ".idle"}, busy, 0);
      check({tag, ".done"}, out_valid, 0);
      check({tag, ".dzhold"}, div_by_zero, dz_exp);
      check({tag, ".early"}, early, 0);
   endtask

   initial begin
      bit seen;
      n_chk  = 0;
      n_pass = 0;
      rst_n  = 1'b0;
      enable = 1'b1;
      start  = 1'b0;
      inbus  = 8'h00;
      repeat (3) tick();
      check("rst.outbus", outbus, 0);
      check("rst.valid", out_valid, 0);
      check("rst.sel", out_sel, 0);
      check("rst.busy", busy, 0);
      check("rst.dz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run_op("d100_7", 8'd7, 8'd100, 8'd2, 8'd14, 1'b0);
      run_op("d255_1", 8'd1, 8'd255, 8'd0, 8'd255, 1'b0);
      run_op("d5_9", 8'd9, 8'd5, 8'd5, 8'd0, 1'b0);
      run_op("d5a_0", 8'd0, 8'h5A, 8'h5A, 8'hFF, 1'b0);
      run_op("d200_13", 8'd13, 8'd200, 8'd5, 8'd15, 1'b0);

      // Abort via enable in cycle 10
      start = 1'b1;
      tick();
      start = 1'b0;
      inbus = 8'd7;
      tick();
      inbus = 8'd100;
      tick();
      inbus = 8'd0;
      for (int c = 3; c < 10; c++) tick();
      enable = 1'b0;
      tick();
      enable = 1'b1;
      check("abort.busy", busy, 0);
      seen = 1'b0;
      for (int c = 0; c < 25; c++) begin
         seen |= out_valid;
         tick();
      end
      check("abort.novld", seen, 0);
      run_op("post_abort", 8'd13, 8'd200, 8'd5, 8'd15, 1'b0);

      run_op("stpulse", 8'd16, 8'd171, 8'd11, 8'd10, 1'b1);

      // Asynchronous reset in a TEST cycle (cycle 7)
      start = 1'b1;
      tick();
      start = 1'b0;
      inbus = 8'd7;
      tick();
      inbus = 8'd100;
      tick();
      inbus = 8'd0;
      for (int c = 3; c < 7; c++) tick();
      check("pre_rst.busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.busy", busy, 0);
      check("arst.outbus", outbus, 0);
      check("arst.valid", out_valid, 0);
      check("arst.dz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("arst.idle", busy, 0);
      run_op("post_rst", 8'd7, 8'd100, 8'd2, 8'd14, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
